ctr_seq: RTL

//  Multi-cycle instruction sequencer for the single-issue RV32 core.

---
 rtl/ctr_seq.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/ctr_seq.sv
`default_nettype none
// ============================================================================
// Module  : ctr_seq
// Brief   : Multi-cycle RV32 instruction sequencer with stage strobes,
//           fetch/memory timeout, and busy-cycle / retired-instruction counters.
// Revision: 1.0  initial release
// ============================================================================
module ctr_seq #(
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 16
) (
    input  logic                  i_sys_clk,
    input  logic                  i_sys_rst_n,
    input  logic                  i_sys_start,
    output logic                  o_sys_busy,
    output logic                  o_sys_halt,
    output logic                  o_sys_err,
    output logic                  o_ifu_req,
    input  logic                  i_ifu_valid,
    output logic                  o_idu_en,
    input  logic                  i_idu_ctr_mem,
    input  logic                  i_idu_ctr_ebreak,
    input  logic                  i_idu_ctr_ill,
    output logic                  o_exu_en,
    output logic                  o_lsu_req,
    input  logic                  i_lsu_ack,
    output logic                  o_wbu_en,
    output logic                  o_pc_wr_en,
    output logic [DATA_WIDTH-1:0] o_cnt_cycle,
    output logic [DATA_WIDTH-1:0] o_cnt_inst
);

    localparam bit            HAS_TIMEOUT = (TIMEOUT > 0);
    localparam int            TW          = HAS_TIMEOUT ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [TW-1:0] TLIM        = HAS_TIMEOUT ? TW'(TIMEOUT - 1) : '0;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6,
        S_ERR    = 3'd7
    } state_e;

    state_e                state_q, state_d;
    logic                  mem_q, mem_d;
    logic [TW-1:0]         timer_q, timer_d;
    logic [DATA_WIDTH-1:0] cnt_cycle_q, cnt_cycle_d;
    logic [DATA_WIDTH-1:0] cnt_inst_q, cnt_inst_d;

    logic busy_q, halt_q, err_q, ifu_req_q, idu_en_q, exu_en_q, lsu_req_q, wbu_en_q, pc_wr_en_q;
    logic busy_d, halt_d, err_d, ifu_req_d, idu_en_d, exu_en_d, lsu_req_d, wbu_en_d, pc_wr_en_d;

    logic          timeout;
    logic [TW-1:0] timer_inc;

    assign timeout   = HAS_TIMEOUT && (timer_q == TLIM);
    assign timer_inc = HAS_TIMEOUT ? timer_q + TW'(1) : '0;

    // Timer defaults to zero so every entry into FETCH/MEM starts a fresh count.
    always_comb begin
        state_d = state_q;
        mem_d   = mem_q;
        timer_d = '0;
        case (state_q)
            S_IDLE:   if (i_sys_start) state_d = S_FETCH;
            S_FETCH: begin
                if (i_ifu_valid)  state_d = S_DECODE;
                else if (timeout) state_d = S_ERR;
                else              timer_d = timer_inc;
            end
            S_DECODE: begin
                mem_d = i_idu_ctr_mem;
                if (i_idu_ctr_ill)         state_d = S_ERR;
                else if (i_idu_ctr_ebreak) state_d = S_HALT;
                else                       state_d = S_EXEC;
            end
            S_EXEC:   state_d = mem_q ? S_MEM : S_WB;
            S_MEM: begin
                if (i_lsu_ack)    state_d = S_WB;
                else if (timeout) state_d = S_ERR;
                else              timer_d = timer_inc;
            end
            S_WB:     state_d = S_FETCH;
            default:  state_d = state_q;
        endcase
    end

    // Outputs are decoded from the next state and registered, so each one
    // is a pure function of the state register with no input-to-output path.
    always_comb begin
        busy_d     = (state_d == S_FETCH) || (state_d == S_DECODE) || (state_d == S_EXEC) ||
                     (state_d == S_MEM)   || (state_d == S_WB);
        halt_d     = (state_d == S_HALT);
        err_d      = (state_d == S_ERR);
        ifu_req_d  = (state_d == S_FETCH);
        idu_en_d   = (state_d == S_DECODE);
        exu_en_d   = (state_d == S_EXEC);
        lsu_req_d  = (state_d == S_MEM);
        wbu_en_d   = (state_d == S_WB);
        pc_wr_en_d = (state_d == S_WB);
    end

    always_comb begin
        cnt_cycle_d = cnt_cycle_q + DATA_WIDTH'(busy_q);
        cnt_inst_d  = cnt_inst_q + DATA_WIDTH'(state_q == S_WB);
    end

    always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
        if (!i_sys_rst_n) begin
            state_q     <= S_IDLE;
            mem_q       <= 1'b0;
            timer_q     <= '0;
            cnt_cycle_q <= '0;
            cnt_inst_q  <= '0;
            busy_q      <= 1'b0;
            halt_q      <= 1'b0;
            err_q       <= 1'b0;
            ifu_req_q   <= 1'b0;
            idu_en_q    <= 1'b0;
            exu_en_q    <= 1'b0;
            lsu_req_q   <= 1'b0;
            wbu_en_q    <= 1'b0;
            pc_wr_en_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem_q       <= mem_d;
            timer_q     <= timer_d;
            cnt_cycle_q <= cnt_cycle_d;
            cnt_inst_q  <= cnt_inst_d;
            busy_q      <= busy_d;
            halt_q      <= halt_d;
            err_q       <= err_d;
            ifu_req_q   <= ifu_req_d;
            idu_en_q    <= idu_en_d;
            exu_en_q    <= exu_en_d;
            lsu_req_q   <= lsu_req_d;
            wbu_en_q    <= wbu_en_d;
            pc_wr_en_q  <= pc_wr_en_d;
        end
    end

    assign o_sys_busy  = busy_q;
    assign o_sys_halt  = halt_q;
    assign o_sys_err   = err_q;
    assign o_ifu_req   = ifu_req_q;
    assign o_idu_en    = idu_en_q;
    assign o_exu_en    = exu_en_q;
    assign o_lsu_req   = lsu_req_q;
    assign o_wbu_en    = wbu_en_q;
    assign o_pc_wr_en  = pc_wr_en_q;
    assign o_cnt_cycle = cnt_cycle_q;
    assign o_cnt_inst  = cnt_inst_q;

endmodule
`default_nettype wire
